// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths and skid-buffer state encoding for the read-path slices.
package axil_pkg;

  localparam int unsigned AXI_ADDR_WIDTH   = 32;
  localparam int unsigned AXI_DATA_WIDTH   = 32;
  localparam int unsigned AXIL_R_PAYLOAD_W = AXI_DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axil_skid_buffer.sv
// Two-entry full-throughput skid buffer; in_ready and out_valid are both registered.
module axil_skid_buffer
  import axil_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_fire && !out_fire) begin
            // Main is stalled, so the new beat parks behind it in the skid slot.
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= SKID_FULL;
          end else if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= SKID_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= SKID_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/axil_reg_slice_rd.sv
// AXI-Lite read-channel register slice: independent AR and R stages, each a skid buffer or a wire.
module axil_reg_slice_rd
  import axil_pkg::*;
#(
  parameter bit AR_REG_EN = 1'b1,
  parameter bit R_REG_EN  = 1'b1
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,
  input  logic                      m_axil_arvalid,
  output logic                      m_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0] m_axil_rdata,
  output logic [1:0]                m_axil_rresp,
  output logic                      m_axil_rvalid,
  input  logic                      m_axil_rready,

  output logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic                      s_axil_arvalid,
  input  logic                      s_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [1:0]                s_axil_rresp,
  input  logic                      s_axil_rvalid,
  output logic                      s_axil_rready
);

  if (AR_REG_EN) begin : g_ar_reg
    axil_skid_buffer #(
      .WIDTH(AXI_ADDR_WIDTH)
    ) u_ar_skid (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_data   (m_axil_araddr),
      .in_valid  (m_axil_arvalid),
      .in_ready  (m_axil_arready),
      .out_data  (s_axil_araddr),
      .out_valid (s_axil_arvalid),
      .out_ready (s_axil_arready)
    );
  end else begin : g_ar_pass
    assign s_axil_araddr  = m_axil_araddr;
    assign s_axil_arvalid = m_axil_arvalid;
    assign m_axil_arready = s_axil_arready;
  end

  if (R_REG_EN) begin : g_r_reg
    logic [AXIL_R_PAYLOAD_W-1:0] r_out_payload;

    axil_skid_buffer #(
      .WIDTH(AXIL_R_PAYLOAD_W)
    ) u_r_skid (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_data   ({s_axil_rresp, s_axil_rdata}),
      .in_valid  (s_axil_rvalid),
      .in_ready  (s_axil_rready),
      .out_data  (r_out_payload),
      .out_valid (m_axil_rvalid),
      .out_ready (m_axil_rready)
    );

    assign {m_axil_rresp, m_axil_rdata} = r_out_payload;
  end else begin : g_r_pass
    assign m_axil_rdata  = s_axil_rdata;
    assign m_axil_rresp  = s_axil_rresp;
    assign m_axil_rvalid = s_axil_rvalid;
    assign s_axil_rready = m_axil_rready;
  end

endmodule

// File: tb/tb_axil_reg_slice_rd.sv
// Directed and randomized checks of the registered read slice against queue-based channel models.
module tb_axil_reg_slice_rd;
  import axil_pkg::*;

  logic                      aclk = 1'b0;
  logic                      aresetn;
  logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr;
  logic                      m_axil_arvalid;
  logic                      m_axil_arready;
  logic [AXI_DATA_WIDTH-1:0] m_axil_rdata;
  logic [1:0]                m_axil_rresp;
  logic                      m_axil_rvalid;
  logic                      m_axil_rready;
  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr;
  logic                      s_axil_arvalid;
  logic                      s_axil_arready;
  logic [AXI_DATA_WIDTH-1:0] s_axil_rdata;
  logic [1:0]                s_axil_rresp;
  logic                      s_axil_rvalid;
  logic                      s_axil_rready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_reg_slice_rd #(
    .AR_REG_EN(1'b1),
    .R_REG_EN (1'b1)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [AXI_ADDR_WIDTH-1:0]   arq[$];
  logic [AXIL_R_PAYLOAD_W-1:0] rq[$];
  int  ar_sent, ar_recv, r_sent, r_recv;
  bit  ar_hold, r_hold, ar_stall, r_stall;
  logic [AXI_ADDR_WIDTH-1:0]   ar_stall_val;
  logic [AXIL_R_PAYLOAD_W-1:0] r_stall_val;

  initial begin
    aresetn        = 1'b0;
    m_axil_araddr  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    s_axil_arready = 1'b0;
    s_axil_rdata   = '0;
    s_axil_rresp   = '0;
    s_axil_rvalid  = 1'b0;

    // Reset held for three cycles, readies and valids low throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("rst_s_arvalid", s_axil_arvalid, 0);
      chk("rst_m_rvalid", m_axil_rvalid, 0);
      chk("rst_m_arready", m_axil_arready, 0);
      chk("rst_s_rready", s_axil_rready, 0);
    end
    chk("rst_s_araddr", s_axil_araddr, 0);
    chk("rst_m_rdata", m_axil_rdata, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_m_arready", m_axil_arready, 1);
    chk("rel_s_rready", s_axil_rready, 1);

    // Single read
    m_axil_arvalid = 1'b1;
    m_axil_araddr  = 32'h0000_1000;
    s_axil_arready = 1'b1;
    m_axil_rready  = 1'b1;
    @(negedge aclk);
    m_axil_arvalid = 1'b0;
    chk("single_s_arvalid", s_axil_arvalid, 1);
    chk("single_s_araddr", s_axil_araddr, 32'h0000_1000);
    @(negedge aclk);
    chk("single_s_arvalid_drop", s_axil_arvalid, 0);
    s_axil_rvalid = 1'b1;
    s_axil_rdata  = 32'hDEAD_BEEF;
    s_axil_rresp  = 2'd0;
    @(negedge aclk);
    s_axil_rvalid = 1'b0;
    chk("single_m_rvalid", m_axil_rvalid, 1);
    chk("single_m_rdata", m_axil_rdata, 32'hDEAD_BEEF);
    chk("single_m_rresp", m_axil_rresp, 0);
    @(negedge aclk);
    chk("single_m_rvalid_drop", m_axil_rvalid, 0);

    // Backpressure fill on AR
    s_axil_arready = 1'b0;
    m_axil_arvalid = 1'b1;
    m_axil_araddr  = 32'h10;
    @(negedge aclk);
    chk("bp_first_valid", s_axil_arvalid, 1);
    chk("bp_first_addr", s_axil_araddr, 32'h10);
    chk("bp_ready_one", m_axil_arready, 1);
    m_axil_araddr = 32'h20;
    @(negedge aclk);
    m_axil_arvalid = 1'b0;
    chk("bp_ready_full", m_axil_arready, 0);
    chk("bp_hold_addr0", s_axil_araddr, 32'h10);
    @(negedge aclk);
    chk("bp_ready_full2", m_axil_arready, 0);
    chk("bp_hold_addr1", s_axil_araddr, 32'h10);
    chk("bp_hold_valid", s_axil_arvalid, 1);
    s_axil_arready = 1'b1;
    @(negedge aclk);
    chk("bp_second_valid", s_axil_arvalid, 1);
    chk("bp_second_addr", s_axil_araddr, 32'h20);
    chk("bp_ready_back", m_axil_arready, 1);
    @(negedge aclk);
    chk("bp_drained", s_axil_arvalid, 0);

    // Streaming 16 R beats with no bubbles
    m_axil_rready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge aclk);
      chk("stream_rvalid", m_axil_rvalid, (k >= 1 && k <= 16) ? 1 : 0);
      if (k >= 1 && k <= 16) chk("stream_rdata", m_axil_rdata, 64'(k - 1));
      if (k < 16) begin
        chk("stream_s_rready", s_axil_rready, 1);
        s_axil_rvalid = 1'b1;
        s_axil_rdata  = 32'(k);
        s_axil_rresp  = 2'd0;
      end else begin
        s_axil_rvalid = 1'b0;
      end
    end

    // Randomized traffic with independent ready toggling on both channels
    ar_sent = 0; ar_recv = 0; r_sent = 0; r_recv = 0;
    ar_hold = 0; r_hold = 0; ar_stall = 0; r_stall = 0;
    for (int cyc = 0; cyc < 20000 && (ar_recv < 1000 || r_recv < 1000); cyc++) begin
      @(negedge aclk);
      if (ar_stall) begin
        chk("ar_stall_valid", s_axil_arvalid, 1);
        chk("ar_stall_addr", s_axil_araddr, ar_stall_val);
      end
      if (r_stall) begin
        chk("r_stall_valid", m_axil_rvalid, 1);
        chk("r_stall_payload", {m_axil_rresp, m_axil_rdata}, r_stall_val);
      end
      if (!ar_hold) begin
        m_axil_arvalid = (ar_sent < 1000) && ($urandom_range(3) != 0);
        m_axil_araddr  = $urandom;
      end
      s_axil_arready = 1'($urandom_range(1));
      if (!r_hold) begin
        s_axil_rvalid = (r_sent < 1000) && ($urandom_range(3) != 0);
        s_axil_rdata  = $urandom;
        s_axil_rresp  = 2'($urandom);
      end
      m_axil_rready = 1'($urandom_range(1));
      #1;
      if (m_axil_arvalid && m_axil_arready) begin
        arq.push_back(m_axil_araddr);
        ar_sent++;
      end
      ar_hold = m_axil_arvalid && !m_axil_arready;
      if (s_axil_arvalid && s_axil_arready) begin
        chk("ar_not_spurious", 64'(arq.size() != 0), 1);
        if (arq.size() != 0) chk("ar_order", s_axil_araddr, arq.pop_front());
        ar_recv++;
      end
      ar_stall     = s_axil_arvalid && !s_axil_arready;
      ar_stall_val = s_axil_araddr;

      if (s_axil_rvalid && s_axil_rready) begin
        rq.push_back({s_axil_rresp, s_axil_rdata});
        r_sent++;
      end
      r_hold = s_axil_rvalid && !s_axil_rready;
      if (m_axil_rvalid && m_axil_rready) begin
        chk("r_not_spurious", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) chk("r_order", {m_axil_rresp, m_axil_rdata}, rq.pop_front());
        r_recv++;
      end
      r_stall     = m_axil_rvalid && !m_axil_rready;
      r_stall_val = {m_axil_rresp, m_axil_rdata};
    end
    chk("ar_count", 64'(ar_recv), 1000);
    chk("r_count", 64'(r_recv), 1000);
    chk("ar_q_empty", 64'(arq.size()), 0);
    chk("r_q_empty", 64'(rq.size()), 0);

    m_axil_arvalid = 1'b0;
    s_axil_rvalid  = 1'b0;
    s_axil_arready = 1'b1;
    m_axil_rready  = 1'b1;
    repeat (4) @(negedge aclk);

    // Reset while the R buffer holds two beats
    m_axil_rready = 1'b0;
    s_axil_rvalid = 1'b1;
    s_axil_rdata  = 32'hAAAA_0001;
    s_axil_rresp  = 2'd1;
    @(negedge aclk);
    s_axil_rdata  = 32'hAAAA_0002;
    @(negedge aclk);
    s_axil_rvalid = 1'b0;
    chk("full_m_rvalid", m_axil_rvalid, 1);
    chk("full_s_rready", s_axil_rready, 0);
    chk("full_m_rdata", m_axil_rdata, 32'hAAAA_0001);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_m_rvalid", m_axil_rvalid, 0);
    chk("async_s_rready", s_axil_rready, 0);
    repeat (2) @(negedge aclk);
    aresetn       = 1'b1;
    m_axil_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("post_rst_no_stale", m_axil_rvalid, 0);
      chk("post_rst_s_rready", s_axil_rready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slice_rd.md
Name: axil_reg_slice_rd

Overview:
AXI-Lite read-channel register slice with full-throughput skid buffers on AR and R. Sits directly upstream of axil_interconnect_rd, one instance per master port, to break timing paths between master logic and the interconnect arbitration/crossbar. Upstream side uses m_axil_* names, downstream side uses s_axil_* names, matching the interconnect's master-facing ports. Each channel can be a registered slice or a zero-latency wire-through.

Parameters:
AR_REG_EN, 1, 1 = AR channel registered through skid buffer; 0 = combinational pass-through
R_REG_EN, 1, 1 = R channel registered through skid buffer; 0 = combinational pass-through
(AXI_ADDR_WIDTH, AXI_DATA_WIDTH come from axil_pkg, not parameters)

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
m_axil_araddr  in  AXI_ADDR_WIDTH  read address from upstream master
m_axil_arvalid  in  1  AR valid from master
m_axil_arready  out  1  AR ready to master
m_axil_rdata  out  AXI_DATA_WIDTH  read data to master
m_axil_rresp  out  2  read response to master
m_axil_rvalid  out  1  R valid to master
m_axil_rready  in  1  R ready from master
s_axil_araddr  out  AXI_ADDR_WIDTH  address toward interconnect master port
s_axil_arvalid  out  1  AR valid toward interconnect
s_axil_arready  in  1  AR ready from interconnect
s_axil_rdata  in  AXI_DATA_WIDTH  read data from interconnect
s_axil_rresp  in  2  read response from interconnect
s_axil_rvalid  in  1  R valid from interconnect
s_axil_rready  out  1  R ready toward interconnect

Behaviour:
- Reset: async assert on aresetn low. s_axil_arvalid=0, m_axil_rvalid=0, m_axil_arready=0, s_axil_rready=0, payload regs=0. Readies go to 1 on the first aclk edge with aresetn high.
- Each registered channel is one skid buffer: main reg (out_valid, out_payload), skid reg (skid_valid, skid_payload). AR payload = araddr. R payload = {rresp, rdata}.
- States: EMPTY (out_valid=0, skid_valid=0), ONE (out_valid=1, skid_valid=0), FULL (out_valid=1, skid_valid=1).
- in_ready is a registered value equal to !skid_valid after the edge. No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Transitions (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready):
  - EMPTY: in_fire -> ONE, main <- input.
  - ONE: in_fire & !out_fire -> FULL, skid <- input. in_fire & out_fire -> ONE, main <- input. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: in_ready=0. out_fire -> ONE, main <- skid. Otherwise hold.
- Latency: 1 cycle input-to-output when EMPTY. Sustained throughput 1 transfer/cycle with out_ready held high.
- Stability: while out_valid=1 & out_ready=0, the output payload must not change (AXI rule). Order is preserved; the skid entry is always older than any new input.
- Pass-through (REG_EN=0): outputs wired directly to inputs, no state, readies follow downstream ready combinationally. Reset values are then those of the driving side.
- AR and R are fully independent. No outstanding-transaction counting; the interconnect decoder owns ordering.
- Reset mid-transfer: all buffered beats are discarded and valids drop asynchronously. Upstream and downstream are required to be reset together.

Decomposition:
- axil_pkg already supplies AXI_ADDR_WIDTH and AXI_DATA_WIDTH. Add localparam AXIL_R_PAYLOAD_W = AXI_DATA_WIDTH+2 to axil_pkg.
- One sub-module, axil_skid_buffer: parameter WIDTH; ports aclk, aresetn, in_data/in_valid/in_ready, out_data/out_valid/out_ready.
  - Instantiate it twice, under generate on AR_REG_EN and R_REG_EN.

Test Plan:
1. Reset release: aresetn low for 3 cycles, then high. Outputs: all valids 0, m_axil_arready=0 and s_axil_rready=0 during reset, both 1 on the first edge after release.
2. Single read: araddr=0x0000_1000 with arvalid for 1 cycle, s_axil_arready=1. s_axil_arvalid rises the next cycle with araddr 0x1000 for exactly 1 cycle. Return rdata=0xDEADBEEF, rresp=0, which appears on the m side 1 cycle later.
3. Backpressure fill: s_axil_arready=0, push addresses 0x10 and 0x20 back-to-back. m_axil_arready drops after the second beat. Output holds 0x10 stable. Release arready and observe 0x10 then 0x20 in consecutive cycles; arready returns to 1.
4. Streaming: 16 R beats rdata=0..15 with m_axil_rready=1. 16 consecutive m_axil_rvalid cycles, in order, no bubbles.
5. Random ready toggling on both sides, 1000 AR and 1000 R beats. Scoreboard requires in-order, lossless, no duplicates, and stable payload while stalled.
6. Reset asserted while FULL (2 R beats buffered). m_axil_rvalid drops without waiting for aclk. After release the buffer is EMPTY and no stale beat is emitted.
